// File: rtl/clk_div_multi.sv
// clk_div_multi
// Multi-channel integer clock divider. Each of NCH channels divides i_ref_clk
// by its own ratio R (2 .. 2**WIDTH-1). The output is high for floor(R/2)
// reference cycles and low for ceil(R/2), so even ratios give exactly 50% duty.
// Ratio and enable are sampled only at period boundaries, so a running output
// never glitches. A channel that is not running passes i_ref_clk straight through.
//
// Ports
//   i_ref_clk    reference clock (single clock domain)
//   i_rst_n      asynchronous active-low reset
//   i_clk_en     per-channel enable
//   i_div_ratio  per-channel ratio; channel k = bits [k*WIDTH +: WIDTH]
//   i_sync       restart every running channel in phase at this edge
//   o_div_clk    divided clock per channel (i_ref_clk while in BYPASS)
//   o_tick       registered one-cycle pulse on the first ref cycle of each period
//   o_active     1 while the channel is dividing (RUN)
module clk_div_multi #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst_n,
  input  logic [NCH-1:0]       i_clk_en,
  input  logic [NCH*WIDTH-1:0] i_div_ratio,
  input  logic                 i_sync,
  output logic [NCH-1:0]       o_div_clk,
  output logic [NCH-1:0]       o_tick,
  output logic [NCH-1:0]       o_active
);

  typedef enum logic {
    ST_BYPASS = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t           state_r [NCH];
  state_t           state_s [NCH];
  logic [WIDTH-1:0] cnt_r   [NCH];
  logic [WIDTH-1:0] cnt_s   [NCH];
  logic [WIDTH-1:0] ract_r  [NCH];
  logic [WIDTH-1:0] ract_s  [NCH];
  logic [WIDTH-1:0] ratio_s [NCH];
  logic [NCH-1:0]   start_s;
  logic [NCH-1:0]   out_r;
  logic [NCH-1:0]   out_s;
  logic [NCH-1:0]   tick_r;
  logic [NCH-1:0]   tick_s;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ratio_s[g] = i_div_ratio[g*WIDTH +: WIDTH];
    // Ratios 0 and 1 cannot be divided; such a channel stays in (or drops to) bypass.
    assign start_s[g] = i_clk_en[g] && (ratio_s[g] >= WIDTH'(2));
    assign o_active[g]  = (state_r[g] == ST_RUN);
    // Bypass passes the reference clock through; RUN drives the glitch-free register.
    assign o_div_clk[g] = (state_r[g] == ST_RUN) ? out_r[g] : i_ref_clk;
  end

  assign o_tick = tick_r;

  // Next-state logic: entry from bypass, period counting, boundary restart/exit.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_s[k] = state_r[k];
      cnt_s[k]   = cnt_r[k];
      ract_s[k]  = ract_r[k];
      out_s[k]   = out_r[k];
      tick_s[k]  = 1'b0;
      case (state_r[k])
        ST_BYPASS: begin
          if (start_s[k]) begin
            state_s[k] = ST_RUN;
            cnt_s[k]   = {WIDTH{1'b0}};
            ract_s[k]  = ratio_s[k];
            out_s[k]   = 1'b1;
            tick_s[k]  = 1'b1;
          end else begin
            state_s[k] = ST_BYPASS;
            cnt_s[k]   = {WIDTH{1'b0}};
            out_s[k]   = 1'b0;
          end
        end
        ST_RUN: begin
          // i_sync forces a boundary; at a real boundary it changes nothing.
          if (i_sync || (cnt_r[k] == ract_r[k] - WIDTH'(1))) begin
            if (start_s[k]) begin
              cnt_s[k]  = {WIDTH{1'b0}};
              ract_s[k] = ratio_s[k];
              out_s[k]  = 1'b1;
              tick_s[k] = 1'b1;
            end else begin
              state_s[k] = ST_BYPASS;
              cnt_s[k]   = {WIDTH{1'b0}};
              out_s[k]   = 1'b0;
            end
          end else begin
            cnt_s[k] = cnt_r[k] + WIDTH'(1);
            // High for the first floor(R/2) counts of the period.
            out_s[k] = ((cnt_r[k] + WIDTH'(1)) < (ract_r[k] >> 1));
          end
        end
        default: begin
          state_s[k] = ST_BYPASS;
          cnt_s[k]   = {WIDTH{1'b0}};
          out_s[k]   = 1'b0;
        end
      endcase
    end
  end

  // Per-channel state registers with asynchronous reset.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        state_r[k] <= ST_BYPASS;
        cnt_r[k]   <= {WIDTH{1'b0}};
        ract_r[k]  <= {WIDTH{1'b0}};
      end
      out_r  <= {NCH{1'b0}};
      tick_r <= {NCH{1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_r[k] <= state_s[k];
        cnt_r[k]   <= cnt_s[k];
        ract_r[k]  <= ract_s[k];
      end
      out_r  <= out_s;
      tick_r <= tick_s;
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
// Self-checking bench for clk_div_multi (WIDTH=8, NCH=2). A behavioural model of
// each channel predicts {o_active, o_tick, o_div_clk} for every reference edge;
// the prediction is queued when the inputs are driven and compared after the edge.
module tb_clk_div_multi;

  localparam int WIDTH = 8;
  localparam int NCH   = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       en;
  logic [NCH*WIDTH-1:0] ratio;
  logic                 sync;
  logic [NCH-1:0]       div_clk;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       active;

  int n_checks;
  int n_errors;

  // Model state per channel
  int m_run [NCH];
  int m_pos [NCH];
  int m_per [NCH];
  int tick_cnt [NCH];

  logic [3*NCH-1:0] sb_q [$];

  clk_div_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .i_sync     (sync),
    .o_div_clk  (div_clk),
    .o_tick     (tick),
    .o_active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one reference edge using the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      int r;
      bit ok;
      r  = int'(ratio[k*WIDTH +: WIDTH]);
      ok = en[k] && (r >= 2);
      if (m_run[k] == 0) begin
        if (ok) begin
          m_run[k] = 1; m_pos[k] = 0; m_per[k] = r;
        end
      end else if (sync || (m_pos[k] == m_per[k] - 1)) begin
        if (ok) begin
          m_pos[k] = 0; m_per[k] = r;
        end else begin
          m_run[k] = 0; m_pos[k] = 0;
        end
      end else begin
        m_pos[k]++;
      end
    end
  endtask

  // Expected outputs sampled while the reference clock is high.
  function automatic logic [3*NCH-1:0] model_out();
    logic [NCH-1:0] a, t, d;
    for (int k = 0; k < NCH; k++) begin
      a[k] = (m_run[k] != 0);
      t[k] = (m_run[k] != 0) && (m_pos[k] == 0);
      d[k] = (m_run[k] != 0) ? (m_pos[k] < m_per[k] / 2) : 1'b1;
    end
    return {a, t, d};
  endfunction

  task automatic run_cycle(input string tag);
    logic [3*NCH-1:0] exp;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, 32'({active, tick, div_clk}), 32'(exp));
    end
    for (int k = 0; k < NCH; k++) if (tick[k]) tick_cnt[k]++;
  endtask

  task automatic clear_ticks();
    for (int k = 0; k < NCH; k++) tick_cnt[k] = 0;
  endtask

  // Assert reset between edges, check reset outputs in both clock phases, release.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_tick",   32'(tick),   32'd0);
    check_eq("rst_div",    32'(div_clk), 32'({NCH{clk}}));
    @(negedge clk);
    #1;
    check_eq("rst_div_low", 32'(div_clk), 32'd0);
    for (int k = 0; k < NCH; k++) begin
      m_run[k] = 0; m_pos[k] = 0; m_per[k] = 0;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en    = 2'b00;
    ratio = 16'd0;
    sync  = 1'b0;
    #2;
    apply_reset();

    // 1: ratio0=4, ratio1=5, both enabled
    en    = 2'b11;
    ratio = {8'd5, 8'd4};
    clear_ticks();
    for (int i = 0; i < 20; i++) run_cycle("t1");
    check_eq("t1_ticks0", 32'(tick_cnt[0]), 32'd5);
    check_eq("t1_ticks1", 32'(tick_cnt[1]), 32'd4);

    // 2: ratio0 4->6 written at cnt=1
    for (int i = 0; i < 8 && m_pos[0] != 1; i++) run_cycle("t2_align");
    check_eq("t2_pos", 32'(m_pos[0]), 32'd1);
    ratio[7:0] = 8'd6;
    for (int i = 0; i < 14; i++) run_cycle("t2");

    // 3: back to ratio 4, drop enable at cnt=1
    ratio[7:0] = 8'd4;
    for (int i = 0; i < 20 && !(m_pos[0] == 1 && m_per[0] == 4); i++) run_cycle("t3_align");
    en[0] = 1'b0;
    for (int i = 0; i < 8 && m_run[0] != 0; i++) run_cycle("t3");
    check_eq("t3_active0", 32'(active[0]), 32'd0);
    @(negedge clk);
    #1;
    check_eq("t3_div_low", 32'(div_clk[0]), 32'd0);

    // 4: ratio 1 then 0 with enable stays in bypass
    en[0] = 1'b1;
    ratio[7:0] = 8'd1;
    clear_ticks();
    for (int i = 0; i < 6; i++) run_cycle("t4_r1");
    ratio[7:0] = 8'd0;
    for (int i = 0; i < 6; i++) run_cycle("t4_r0");
    check_eq("t4_ticks0", 32'(tick_cnt[0]), 32'd0);
    @(negedge clk);
    #1;
    check_eq("t4_div_low", 32'(div_clk[0]), 32'd0);

    // 5: ch0 at cnt=4, ch1 at cnt=1 (ratio 6), then i_sync
    @(posedge clk);
    #1;
    apply_reset();
    en    = 2'b01;
    ratio = {8'd6, 8'd6};
    run_cycle("t5_a");
    run_cycle("t5_b");
    run_cycle("t5_c");
    en = 2'b11;
    run_cycle("t5_d");
    run_cycle("t5_e");
    check_eq("t5_pos0", 32'(m_pos[0]), 32'd4);
    check_eq("t5_pos1", 32'(m_pos[1]), 32'd1);
    sync = 1'b1;
    run_cycle("t5_sync");
    check_eq("t5_sync_tick", 32'(tick), 32'b11);
    sync = 1'b0;
    for (int i = 0; i < 12; i++) run_cycle("t5");

    // 6: asynchronous reset mid-period, then ratio 3
    #2;
    apply_reset();
    en    = 2'b01;
    ratio = {8'd0, 8'd3};
    clear_ticks();
    for (int i = 0; i < 9; i++) run_cycle("t6");
    check_eq("t6_ticks0", 32'(tick_cnt[0]), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
